// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared types for the camera capture block: capture FSM
//                state encoding, camera byte-format encodings and the
//                12-bit RGB444 pixel type.
//  Revision    : 1.0  initial release
// ============================================================================
package cam_pkg;

  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_WAIT_VS    = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_ACTIVE     = 2'd2
  } cam_state_e;

  typedef enum logic [1:0] {
    MODE_RGB565  = 2'd0,
    MODE_XRGB444 = 2'd1,
    MODE_YUV422  = 2'd2,
    MODE_RSVD    = 2'd3
  } cam_mode_e;

endpackage : cam_pkg
`default_nettype wire

// File: rtl/pix_fmt_conv.sv
`default_nettype none
// ============================================================================
//  Module      : pix_fmt_conv
//  Description : Combinational conversion of one two-byte camera pixel into
//                a 12-bit RGB444 word.
//  Ports       : mode - byte format of the pair (reserved code acts as RGB565)
//                b0   - first byte of the pixel
//                b1   - second byte of the pixel
//                pix  - RGB444 result {R[3:0], G[3:0], B[3:0]}
//  Revision    : 1.0  initial release
// ============================================================================
module pix_fmt_conv
  import cam_pkg::*;
(
  input  cam_mode_e  mode,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output pix_t       pix
);

  always_comb begin
    pix = '0;
    case (mode)
      MODE_XRGB444: pix = {b0[3:0], b1[7:0]};
      // Luma only: replicate the top nibble of Y into all three channels.
      MODE_YUV422:  pix = {b0[7:4], b0[7:4], b0[7:4]};
      // RGB565 (and the reserved code): keep the top nibble of R, the top
      // four bits of the six-bit G field straddling both bytes, top of B.
      default:      pix = {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endcase
  end

endmodule : pix_fmt_conv
`default_nettype wire

// File: rtl/cam_capture_param.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture_param
//  Description : Parameterised camera (OV76xx-style) capture front end.
//                Registers VSYNC/HREF/data, pairs bytes into pixels, converts
//                them to RGB444, decimates by DEC in both axes and emits
//                frame-buffer write strobes with a running address.
//  Ports       : clk          - camera pixel clock
//                reset        - asynchronous active-high reset
//                vsync, href  - camera frame / line qualifiers
//                d            - camera data byte
//                mode         - byte format, latched at frame start
//                capture_en   - capture the frame that starts next
//                addr, dout   - write address and RGB444 pixel
//                we           - single-cycle write strobe
//                frame_done   - pulse when a captured frame ends
//                frame_count  - completed captured frames (wraps)
//                overflow     - sticky: address limit hit this frame
//  Revision    : 1.0  initial release
// ============================================================================
module cam_capture_param
  import cam_pkg::*;
#(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int DEC    = 2,
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic [1:0]        mode,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              overflow
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (!(DEC == 1 || DEC == 2 || DEC == 4)) begin : g_bad_dec
    $fatal(1, "cam_capture_param: DEC must be 1, 2 or 4");
  end
  if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $fatal(1, "cam_capture_param: DEPTH exceeds 2**ADDR_W");
  end

  localparam int                CNT_W     = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  H_LIM     = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0]  V_LIM     = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0]  DEC_MASK  = CNT_W'(DEC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic              vs_q, vs_d, hr_q, hr_d;
  logic [7:0]        d_q, d_d;
  logic              vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  cam_state_e        state_q, state_d;
  cam_mode_e         mode_q, mode_d;
  logic              phase_q, phase_d;
  logic [7:0]        b0_q, b0_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              we_q, we_d;
  pix_t              dout_q, dout_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_count_q, frame_count_d;

  logic vs_rise, vs_fall, pix_keep;
  pix_t pix;

  pix_fmt_conv u_conv (
    .mode (mode_q),
    .b0   (b0_q),
    .b1   (d_q),
    .pix  (pix)
  );

  assign vs_rise = vs_q & ~vs_prev_q;
  assign vs_fall = ~vs_q & vs_prev_q;

  // Decimation and active-window qualification for the pixel completing now.
  assign pix_keep = ((x_q & DEC_MASK) == '0) && ((y_q & DEC_MASK) == '0) &&
                    (x_q < H_LIM) && (y_q < V_LIM);

  always_comb begin
    vs_d          = vsync;
    hr_d          = href;
    d_d           = d;
    vs_prev_d     = vs_q;
    hr_prev_d     = hr_q;
    state_d       = state_q;
    mode_d        = mode_q;
    phase_d       = phase_q;
    b0_d          = b0_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    full_d        = full_q;
    overflow_d    = overflow_q;
    we_d          = 1'b0;
    dout_d        = dout_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    // The address advances in the cycle the write is presented. The last
    // word is never stepped past; full_q marks it as consumed instead.
    if (we_q) begin
      if (addr_q == LAST_ADDR) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    case (state_q)
      ST_WAIT_VS: begin
        if (vs_q) begin
          state_d = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (vs_fall) begin
          if (capture_en) begin
            state_d    = ST_ACTIVE;
            mode_d     = cam_mode_e'(mode);
            addr_d     = '0;
            full_d     = 1'b0;
            overflow_d = 1'b0;
            x_d        = '0;
            y_d        = '0;
            phase_d    = 1'b0;
          end else begin
            state_d = ST_WAIT_VS;
          end
        end
      end

      ST_ACTIVE: begin
        if (vs_rise) begin
          // Ends the frame, and aborts any line still in flight.
          state_d       = ST_WAIT_START;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          phase_d       = 1'b0;
        end else if (hr_q) begin
          if (!phase_q) begin
            b0_d    = d_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q != CNT_MAX) begin
              x_d = x_q + 1'b1;
            end
            if (pix_keep) begin
              if (full_q) begin
                overflow_d = 1'b1;
              end else begin
                we_d   = 1'b1;
                dout_d = pix;
              end
            end
          end
        end else begin
          // Dropping the phase here discards an odd trailing byte.
          phase_d = 1'b0;
          if (hr_prev_q) begin
            x_d = '0;
            if (x_q != '0 && y_q != CNT_MAX) begin
              y_d = y_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q          <= 1'b0;
      hr_q          <= 1'b0;
      d_q           <= '0;
      vs_prev_q     <= 1'b0;
      hr_prev_q     <= 1'b0;
      state_q       <= ST_WAIT_VS;
      mode_q        <= MODE_RGB565;
      phase_q       <= 1'b0;
      b0_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      we_q          <= 1'b0;
      dout_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      vs_q          <= vs_d;
      hr_q          <= hr_d;
      d_q           <= d_d;
      vs_prev_q     <= vs_prev_d;
      hr_prev_q     <= hr_prev_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      phase_q       <= phase_d;
      b0_q          <= b0_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      we_q          <= we_d;
      dout_q        <= dout_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign addr        = addr_q;
  assign dout        = dout_q;
  assign we          = we_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule : cam_capture_param
`default_nettype wire

// File: tb/tb_cam_capture_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_capture_param
//  Description : Scoreboard testbench for cam_capture_param with a small
//                frame geometry. Frames are generated as byte lists, a
//                reference model derives the expected writes and frame
//                results, and a monitor pops and compares on we/frame_done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cam_capture_param;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int DEC   = 2;
  localparam int AW    = 5;
  localparam int DEPTH = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    d = '0;
  logic [1:0]    mode = '0;
  logic          capture_en = 1'b0;
  logic [AW-1:0] addr;
  logic [11:0]   dout;
  logic          we;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          overflow;

  cam_capture_param #(
    .H_ACT (H), .V_ACT (V), .DEC (DEC), .ADDR_W (AW), .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .href        (href),
    .d           (d),
    .mode        (mode),
    .capture_en  (capture_en),
    .addr        (addr),
    .dout        (dout),
    .we          (we),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [11:0] px; } wr_t;
  typedef struct { logic [7:0] cnt; logic ovf; } fr_t;

  wr_t        wq[$];
  fr_t        fq[$];
  logic [7:0] fb[$];
  int         fl[$];
  logic [7:0] exp_count = '0;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [1:0] m, input logic [7:0] b0,
                                          input logic [7:0] b1);
    case (m)
      2'd1:    return {b0[3:0], b1};
      2'd2:    return {b0[7:4], b0[7:4], b0[7:4]};
      default: return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endcase
  endfunction

  // Behavioural model of one captured frame: walk lines, pair bytes into
  // pixels, keep every DEC-th pixel of every DEC-th non-empty line inside
  // the active window, and stop writing once DEPTH words have been used.
  function automatic void model_frame(input logic [1:0] m);
    int  a   = 0;
    int  y   = 0;
    int  idx = 0;
    bit  ovf = 1'b0;
    fr_t f;
    foreach (fl[l]) begin
      int np;
      np = fl[l] / 2;
      for (int x = 0; x < np; x++) begin
        if (x % DEC == 0 && y % DEC == 0 && x < H && y < V) begin
          if (a < DEPTH) begin
            wq.push_back('{AW'(a), ref_pix(m, fb[idx + 2*x], fb[idx + 2*x + 1])});
            a++;
          end else begin
            ovf = 1'b1;
          end
        end
      end
      if (np > 0) y++;
      idx += fl[l];
    end
    exp_count = exp_count + 8'd1;
    f.cnt = exp_count;
    f.ovf = ovf;
    fq.push_back(f);
  endfunction

  // Monitor: compare whenever the DUT presents a write or a frame end.
  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        if (wq.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", addr, w.a);
          check("wr_dout", dout, w.px);
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          fr_t f;
          f = fq.pop_front();
          check("frame_count", frame_count, f.cnt);
          check("overflow", overflow, f.ovf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wq.delete();
    fq.delete();
    exp_count = '0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] gen_byte(input int pat, input int i);
    case (pat)
      1:       return (i % 2 == 0) ? 8'hF8 : 8'h1F;
      2:       return (i % 2 == 0) ? 8'h0A : 8'hBC;
      3:       return (i % 2 == 0) ? 8'h95 : 8'h33;
      default: return 8'($urandom);
    endcase
  endfunction

  // One frame: vsync high period, then nlines lines of bytes. len < 0 picks
  // random line lengths (odd lengths included). rst_line >= 0 asserts reset
  // at byte 10 of that line.
  task automatic run_frame(input bit cap, input logic [1:0] m, input int pat,
                           input int nlines, input int len, input bit abort,
                           input int rst_line);
    int idx;
    fb.delete();
    fl.delete();
    for (int l = 0; l < nlines; l++) begin
      int n;
      n = (len < 0) ? int'($urandom_range(0, 40)) : len;
      fl.push_back(n);
      for (int i = 0; i < n; i++) fb.push_back(gen_byte(pat, i));
    end
    vsync = 1'b1;
    mode = m;
    capture_en = cap;
    repeat (3) tick();
    if (cap) model_frame(m);
    vsync = 1'b0;
    repeat (4) tick();
    idx = 0;
    for (int l = 0; l < nlines; l++) begin
      // Mid-frame changes to mode/capture_en must not matter.
      mode = 2'($urandom);
      capture_en = 1'($urandom);
      for (int i = 0; i < fl[l]; i++) begin
        if (l == rst_line && i == 10) do_reset();
        href = 1'b1;
        d = fb[idx];
        idx++;
        tick();
      end
      if (abort && l == nlines - 1) begin
        vsync = 1'b1;
        href = 1'b1;
        d = 8'($urandom);
        tick();
      end
      href = 1'b0;
      d = '0;
      repeat (2 + $urandom_range(0, 2)) tick();
    end
    repeat (2) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();

    // Directed formats; the RGB565 frame is long enough to overflow.
    run_frame(1'b1, 2'd0, 1, 8, 32, 1'b0, -1);
    run_frame(1'b1, 2'd1, 2, 4, 16, 1'b0, -1);
    run_frame(1'b1, 2'd2, 3, 5, 20, 1'b0, -1);
    run_frame(1'b1, 2'd3, 1, 3, 17, 1'b0, -1);
    // Skipped frame, then capture resumes from address 0.
    run_frame(1'b0, 2'd1, 0, 6, -1, 1'b0, -1);
    run_frame(1'b1, 2'd1, 0, 6, -1, 1'b0, -1);
    // Line aborted by vsync rising while href is high.
    run_frame(1'b1, 2'd0, 0, 4, 30, 1'b1, -1);

    for (int k = 0; k < 30; k++) begin
      run_frame($urandom_range(0, 9) != 0, 2'($urandom), 0, $urandom_range(0, 10),
                -1, $urandom_range(0, 4) == 0, -1);
    end

    // Reset mid-line; the remainder of that frame must be ignored.
    run_frame(1'b1, 2'd1, 0, 6, 24, 1'b0, 3);
    run_frame(1'b1, 2'd2, 0, 6, -1, 1'b0, -1);
    run_frame(1'b1, 2'd0, 0, 9, 36, 1'b0, -1);

    // Empty frames still pulse frame_done; enough of them to wrap the count.
    for (int k = 0; k < 260; k++) run_frame(1'b1, 2'd0, 0, 0, 0, 1'b0, -1);

    vsync = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 50 && (wq.size() != 0 || fq.size() != 0); i++) tick();
    check("pending_writes", wq.size(), 0);
    check("pending_frames", fq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cam_capture_param
`default_nettype wire

// File: doc/cam_capture_param.md
CAM_CAPTURE_PARAM -- requirements
Module: cam_capture_param

Interface
REQ-001 Parameter H_ACT, default 640: active pixels per camera line.
REQ-002 Parameter V_ACT, default 480: active lines per camera frame.
REQ-003 Parameter DEC, default 2: decimation factor in each axis; legal values 1, 2, 4.
REQ-004 Parameter ADDR_W, default 18: frame-buffer address width.
REQ-005 Parameter DEPTH, default 76800: frame-buffer words; DEPTH SHALL NOT exceed 2^ADDR_W.
REQ-006 Port clk, input, 1: sole clock, the camera pixel clock; all logic rising-edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port vsync, input, 1: camera VSYNC, high between frames.
REQ-009 Port href, input, 1: camera HREF, high during active line bytes.
REQ-010 Port d, input, 8: camera pixel byte.
REQ-011 Port mode, input, 2: 0 = RGB565, 1 = xRGB444, 2 = YUV422 (YUYV) luma, 3 = reserved (treated as 0).
REQ-012 Port capture_en, input, 1: enable capture of the next frame.
REQ-013 Port addr, output, ADDR_W: write address.
REQ-014 Port dout, output, 12: RGB444 pixel.
REQ-015 Port we, output, 1: write strobe.
REQ-016 Port frame_done, output, 1: one-cycle pulse at the end of each captured frame.
REQ-017 Port frame_count, output, 8: number of completed captured frames.
REQ-018 Port overflow, output, 1: sticky flag; address limit reached in the current frame.

Function
REQ-019 The block SHALL register vsync, href and d once and SHALL use only the registered copies internally.
REQ-020 FSM states:
- WAIT_VS: wait for vsync high.
- WAIT_START: go to ACTIVE on vsync falling edge if capture_en=1; otherwise return to WAIT_VS.
- ACTIVE: on vsync rising edge go to WAIT_START.
REQ-021 On entry to ACTIVE, the block SHALL clear addr, the x/y counters, the byte phase and overflow, and SHALL latch mode; a mode change mid-frame SHALL have no effect.
REQ-022 Byte handling:
- While href=1, the byte phase SHALL toggle every cycle; phase 0 latches byte0, phase 1 completes the pixel.
- href low SHALL reset the phase to 0.
- An odd trailing byte SHALL be discarded.
REQ-023 Pixel formats:
- RGB565: dout = {b0[7:4], b0[2:0], b1[7], b1[4:1]}.
- xRGB444: dout = {b0[3:0], b1[7:0]}.
- YUV: dout = {b0[7:4], b0[7:4], b0[7:4]}.
REQ-024 Counters and write qualification:
- x counts completed pixels per line and clears on the href falling edge.
- y increments on each href falling edge that had at least one pixel.
- A pixel SHALL be written only when x mod DEC = 0 and y mod DEC = 0, and x < H_ACT and y < V_ACT.
REQ-025 we SHALL assert exactly one cycle, on the cycle after the phase-1 byte is sampled; addr and dout SHALL be valid in the same cycle.
REQ-026 addr SHALL increment after each write.
REQ-027 When a write would use addr = DEPTH, the block SHALL suppress the write, set overflow and hold addr at DEPTH-1 until the next frame start.
REQ-028 On the vsync rising edge in ACTIVE, frame_done SHALL pulse for one cycle and frame_count SHALL increment, wrapping 255 to 0.
REQ-029 A frame that ends with zero writes SHALL still pulse frame_done.
REQ-030 A vsync rising edge while href=1 SHALL abort the line: no further writes, and frame_done SHALL pulse.

Reset
REQ-031 Asserting reset at any time, including mid-frame, SHALL force: state WAIT_VS, addr=0, dout=0, we=0, frame_done=0, frame_count=0, overflow=0, phase=0, and input registers=0.
REQ-032 After reset release, the first frame SHALL NOT be captured until a complete vsync high-to-low transition is observed.

Structure
REQ-033 The FSM state encoding, the mode encodings and the 12-bit pixel width SHALL live in the shared package cam_pkg.
REQ-034 Pixel format conversion SHALL be a combinational sub-module, pix_fmt_conv (inputs mode, b0, b1; output 12-bit pixel).
REQ-035 Elaboration SHALL fail if DEC is not in {1, 2, 4} or if DEPTH > 2^ADDR_W.

Verification
REQ-036 RGB565 mode, DEC=1, H_ACT=4, V_ACT=2, bytes 0xF8,0x1F repeated -> 8 writes, addr 0..7, dout=0xF0F each.
REQ-037 xRGB444 mode, DEC=2, 640x480 frame of bytes 0x0A,0xBC -> 76800 writes of dout=0xABC, then frame_done pulse and frame_count=1.
REQ-038 YUV mode, byte sequence Y=0x95, U=0x33 -> dout=0x999 on every written pixel.
REQ-039 DEC=1, DEPTH=76800, full 640x480 frame -> writes stop at addr 76799 and overflow=1; next frame start clears overflow.
REQ-040 capture_en=0 at a vsync falling edge -> zero writes for that frame and frame_count unchanged; capture_en=1 at the next falling edge -> capture resumes at addr 0.
REQ-041 reset asserted at pixel 100 of line 10 -> all outputs zero on the next edge; the partial frame after release is ignored and the following full frame is captured from addr 0.
